// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target responder
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int BYTE_BITS = 8;
  localparam int CNT_W = $clog2(BYTE_BITS);
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer plus rise/fall detect for one bus line.
// I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic filt_q, filt_d;
  logic s;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    hist_d = {hist_q[0], s};
    filt_d = (s & hist_q[0]) | (s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end
  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = level;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;
endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: oversampled I2C target with address match, write receive and read transmit.
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables majority filtering on scl/sda.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, rx_byte;
  logic rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, ack_pend_q, ack_pend_d;
  logic rx_valid_q, rx_valid_d, addr_hit_q, addr_hit_d, tx_req_q, tx_req_d;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .reset_n(reset_n), .d_in(scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .reset_n(reset_n), .d_in(sda_in), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  // an scl rise coinciding with an sda change is a data bit, not a bus condition
  assign start = sda_fall & scl_lvl & ~scl_rise;
  assign stop  = sda_rise & scl_lvl & ~scl_rise;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    rw_d = rw_q;
    sda_oe_d = sda_oe_q;
    rx_data_d = rx_data_q;
    busy_d = busy_q;
    ack_pend_d = ack_pend_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    tx_req_d = 1'b0;
    rx_byte = {shift_q[6:0], sda_lvl};
    if (start || stop) begin
      state_d = start ? ADDR : IDLE;
      busy_d = start;
      cnt_d = '0;
      sda_oe_d = 1'b0;
      ack_pend_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, WR_DATA: if (!ack_pend_q) begin
          shift_d = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BYTE_BITS - 1)) begin
            if (state_q == ADDR) begin
              rw_d = rx_byte[0];
              ack_pend_d = rx_byte[7:1] == SLAVE_ADDR;
              tx_req_d = (rx_byte[7:1] == SLAVE_ADDR) & rx_byte[0];
              state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR : WAIT_STOP;
            end else begin
              rx_data_d = rx_byte;
              rx_valid_d = 1'b1;
              ack_pend_d = 1'b1;
            end
          end
        end
        RD_DATA: cnt_d = cnt_q + 1'b1;
        RD_ACK: begin
          tx_req_d = sda_lvl == I2C_ACK;
          state_d = (sda_lvl == I2C_ACK) ? RD_ACK : WAIT_STOP;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ADDR, WR_DATA: if (ack_pend_q) begin
          ack_pend_d = 1'b0;
          sda_oe_d = 1'b1;
          addr_hit_d = state_q == ADDR;
          state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
        end
        ADDR_ACK, RD_ACK: begin
          cnt_d = '0;
          if (state_q == RD_ACK || rw_q) begin
            sda_oe_d = ~tx_data[7];
            shift_d = {tx_data[6:0], 1'b0};
            state_d = RD_DATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d = WR_DATA;
          end
        end
        WR_ACK: begin
          sda_oe_d = 1'b0;
          state_d = WR_DATA;
        end
        // cnt wraps to 0 after the 8th rise, so this fall ends the byte
        RD_DATA: if (cnt_q == '0) begin
          sda_oe_d = 1'b0;
          state_d = RD_ACK;
        end else begin
          sda_oe_d = ~shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      rw_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rx_data_q <= '0;
      busy_q <= 1'b0;
      ack_pend_q <= 1'b0;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      tx_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      rw_q <= rw_d;
      sda_oe_q <= sda_oe_d;
      rx_data_q <= rx_data_d;
      busy_q <= busy_d;
      ack_pend_q <= ack_pend_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      tx_req_q <= tx_req_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign tx_req = tx_req_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign rw = rw_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-level master model with scoreboards for written and read bytes.
module tb_i2c_slave_responder;
  localparam int Q = 5;
  logic clk = 1'b0, reset_n = 1'b0, scl = 1'b1, sda_m = 1'b1, sda_in;
  logic sda_oe, tx_req, rx_valid, addr_hit, rw, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  int n_chk = 0, n_fail = 0, rxv_cnt = 0, txr_cnt = 0, hit_cnt = 0;
  logic oe_seen = 1'b0;
  logic [7:0] rx_q[$], rd_q[$], tx_src[$];

  assign sda_in = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr_hit(addr_hit), .rw(rw), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      rxv_cnt++;
      if (rx_q.size() == 0) check("rx_extra", rx_q.size(), 1);
      else check("rx_data", rx_data, rx_q.pop_front());
    end
    if (tx_req) begin
      txr_cnt++;
      if (tx_src.size() != 0) tx_data = tx_src.pop_front();
      else tx_data = 8'hFF;
    end
    if (addr_hit) hit_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_bit(input logic b, input logic glitch, output logic smp, output logic so);
    clks(Q); sda_m = b;
    clks(Q); scl = 1'b1;
    clks(Q); smp = sda_in; so = sda_oe;
    if (glitch) begin
      scl = 1'b0; clks(1); scl = 1'b1;
    end
    clks(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(Q); sda_m = 1'b0;
    clks(Q); scl = 1'b1;
    clks(Q); sda_m = 1'b1;
    clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int gpos, output logic ack);
    logic s, so;
    for (int i = 7; i >= 0; i--) do_bit(b[i], (7 - i) == gpos, s, so);
    do_bit(1'b1, 1'b0, s, so);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_ack);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      do_bit(1'b1, 1'b0, s, oe_ack);
      d = {d[6:0], s};
    end
    do_bit(mack, 1'b0, s, oe_ack);
  endtask

  initial begin
    logic ack, oe;
    logic [7:0] d;
    int base;
    clks(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {tx_req, rx_valid, addr_hit}, 0);
    check("rst_rw_rx", {rw, rx_data}, 0);
    reset_n = 1'b1;
    clks(4);

    i2c_start();
    write_byte(8'h84, -1, ack); check("w_addr_ack", ack, 1);
    rx_q.push_back(8'hA5); write_byte(8'hA5, -1, ack); check("w_b1_ack", ack, 1);
    rx_q.push_back(8'h3C); write_byte(8'h3C, -1, ack); check("w_b2_ack", ack, 1);
    check("w_busy", busy, 1);
    check("w_rw", rw, 0);
    i2c_stop(); clks(4);
    check("w_busy_end", busy, 0);
    check("w_hits", hit_cnt, 1);
    check("w_rxv", rxv_cnt, 2);

    oe_seen = 1'b0; base = rxv_cnt;
    i2c_start();
    write_byte(8'h86, -1, ack); check("bad_addr_ack", ack, 0);
    write_byte(8'h11, -1, ack); check("bad_data_ack", ack, 0);
    check("bad_busy", busy, 1);
    i2c_stop(); clks(4);
    check("bad_busy_end", busy, 0);
    check("bad_oe_seen", oe_seen, 0);
    check("bad_rxv", rxv_cnt, base);

    base = txr_cnt;
    tx_src.push_back(8'hC3); rd_q.push_back(8'hC3);
    tx_src.push_back(8'h5A); rd_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h85, -1, ack); check("r_addr_ack", ack, 1);
    check("r_rw", rw, 1);
    read_byte(1'b0, d, oe); check("r_byte1", d, rd_q.pop_front()); check("r_mack_oe1", oe, 0);
    read_byte(1'b1, d, oe); check("r_byte2", d, rd_q.pop_front()); check("r_mack_oe2", oe, 0);
    i2c_stop(); clks(4);
    check("r_txreq", txr_cnt - base, 2);
    check("r_hits", hit_cnt, 2);

    base = rxv_cnt;
    tx_src.push_back(8'h96); rd_q.push_back(8'h96);
    i2c_start();
    write_byte(8'h84, -1, ack); check("rs_waddr_ack", ack, 1);
    for (int i = 0; i < 4; i++) do_bit(1'b1, 1'b0, ack, oe);
    i2c_start();
    write_byte(8'h85, -1, ack); check("rs_raddr_ack", ack, 1);
    read_byte(1'b1, d, oe); check("rs_byte", d, rd_q.pop_front());
    check("rs_rw", rw, 1);
    i2c_stop(); clks(4);
    check("rs_rxv", rxv_cnt, base);

    tx_src.push_back(8'h00);
    i2c_start();
    write_byte(8'h85, -1, ack); check("rst_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) do_bit(1'b1, 1'b0, ack, oe);
    clks(2 * Q - 1);
    check("rst_pre_oe", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_oe", sda_oe, 0);
    check("rst_async_busy", busy, 0);
    clks(3); scl = 1'b1; sda_m = 1'b1;
    clks(3); reset_n = 1'b1; clks(Q);
    i2c_start();
    write_byte(8'h84, -1, ack); check("post_rst_addr_ack", ack, 1);
    rx_q.push_back(8'h77); write_byte(8'h77, -1, ack); check("post_rst_ack", ack, 1);
    i2c_stop(); clks(4);

    base = rxv_cnt;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    rx_q.push_back(8'hA5);
`else
    rx_q.push_back(8'hB2);
`endif
    i2c_start();
    write_byte(8'h84, -1, ack); check("gl_addr_ack", ack, 1);
    write_byte(8'hA5, 2, ack);
    i2c_stop(); clks(4);
    check("gl_rxv", rxv_cnt - base, 1);

    check("rx_q_empty", rx_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
I2C target (slave) responder, the other end of the bus from the master's SCL generator. It oversamples the external SCL and SDA lines with the system clock, detects START/STOP, matches a 7-bit address, and ACKs it. It receives write bytes into rx_data and shifts tx_data out on reads. SDA is open-drain: the block only pulls it low, via sda_oe.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit bus address this target answers to
SYNC_STAGES, 2, flip-flop stages on scl/sda inputs (min 2)

Ports:
clk  input  1  system clock, must be >= 8x SCL frequency
reset_n  input  1  asynchronous active-low reset
scl  input  1  bus SCL (asynchronous)
sda_in  input  1  bus SDA sampled value (asynchronous)
sda_oe  output  1  1 = pull SDA low, 0 = release
tx_data  input  8  byte to return on read
tx_req  output  1  one-clk pulse: load next tx_data
rx_data  output  8  last received write byte
rx_valid  output  1  one-clk pulse: rx_data updated
addr_hit  output  1  one-clk pulse: address matched, ACK being driven
rw  output  1  R/W bit of the current transfer (1 = read)
busy  output  1  high from START to STOP

Behaviour:
- Reset (async, reset_n low): all outputs 0, state IDLE, shift/bit counters 0. Synchronizers reset to 1 (bus idle).
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized values, one register later.
- START: sda falls while scl high. Recognized in any state: restarts at ADDR, bit count 0, busy=1, sda_oe=0.
- STOP: sda rises while scl high. Recognized in any state: go to IDLE, busy=0, sda_oe=0.
- Data sampled on scl rising edge, MSB first. sda_oe changes only on detected scl falling edge (1 clk after the synchronized fall).
- Bit counter 3 bits, wraps 7->0 at byte end.
- States:
  IDLE: wait for START.
  ADDR: shift 8 bits; on 8th rise compare [7:1] to SLAVE_ADDR and latch rw=[0]. On match, at next fall set sda_oe=1 and go to ADDR_ACK; pulse addr_hit on that fall. On mismatch go to WAIT_STOP, sda_oe stays 0.
  ADDR_ACK: on the fall ending the ACK bit, go to WR_DATA (rw=0) or RD_DATA (rw=1). For a read, load tx shift register from tx_data and drive bit7 on the same fall.
  WR_DATA: shift 8 bits; on 8th rise copy to rx_data and pulse rx_valid; at next fall sda_oe=1, go WR_ACK.
  WR_ACK: on the fall ending the ACK bit, sda_oe=0, go WR_DATA. Every byte is ACKed; there is no NACK-on-full.
  RD_DATA: on each fall, sda_oe = ~shift[7], then shift left. After 8 bits release (sda_oe=0), go RD_ACK.
  RD_ACK: sample master ACK on the rise. ACK (0): pulse tx_req on that rise; on the following fall load tx_data, go RD_DATA. NACK (1): go WAIT_STOP.
  WAIT_STOP: sda_oe=0, ignore bits until STOP or repeated START.
- tx_req also pulses on the ADDR rise that produces a read-match, so the first tx_data is requested before the ADDR_ACK fall. tx_data must be stable from the tx_req pulse until the next scl fall.
- START/STOP take priority over a simultaneous scl edge in the same clk. A repeated START mid-byte aborts the byte: no rx_valid.
- A scl rise and a sda change on the same clk are treated as a data bit, not START/STOP.

Optional Feature:
I2C_SLAVE_GLITCH_FILTER_EN
- Defined: after synchronization, scl and sda each pass a 3-sample majority filter. Pulses of 1 clk are suppressed; edge latency grows by 2 clk.
- Undefined: synchronized values are used directly.
- Protocol behaviour is otherwise identical.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP), I2C_ACK=1'b0, I2C_NACK=1'b1, BYTE_BITS=8.
- Sub-module i2c_line_sync: synchronizer, optional filter, rise/fall outputs. Instantiated once each for scl and sda.

Test Plan:
- Reset mid-transfer: assert reset_n low during an RD_DATA bit -> sda_oe=0 and busy=0 immediately (async). Next START is accepted normally.
- Write 0x84 (addr 0x42, W), then 0xA5, 0x3C, STOP -> ACK on all 3 bytes; addr_hit once; rx_valid pulses twice with rx_data 0xA5 then 0x3C; rw=0; busy falls after STOP.
- Address 0x43 W, 0x11 -> no ACK (sda_oe never 1), no rx_valid, busy stays high until STOP.
- Read 0x85, tx_data 0xC3 then 0x5A; master ACKs byte 1, NACKs byte 2 -> SDA bits 11000011, 01011010; tx_req pulses 2 times; sda_oe=0 in both master-ACK slots.
- Repeated START after 4 bits of a write byte, then 0x85 -> no rx_valid for the partial byte; read proceeds, rw=1.
- With I2C_SLAVE_GLITCH_FILTER_EN: 1-clk low glitch on scl mid-bit -> no extra bit shifted. Without the macro, the same glitch corrupts the byte (expected).
